// File: rtl/i2s_deserializer_pkg.sv
// Shared definitions for the I2S receive path: default word width, FSM
// encodings and the bit-counter width helper.
package i2s_deserializer_pkg;

    localparam int DATA_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        RUN     = 2'd2
    } state_e;

    // The counter must reach DATA_WIDTH+1 so that it can saturate there.
    function automatic int cnt_width(input int data_width);
        return $clog2(data_width + 2);
    endfunction

endpackage

// File: rtl/i2s_word_assembler.sv
// Shifts in sd on rising sck, counts bits per word and flags the ws edge
// that closes a word (the sample carrying that word's LSB).
module i2s_word_assembler
    import i2s_deserializer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int CNT_W      = cnt_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample,
    input  logic                  sd,
    input  logic                  ws,
    output logic [DATA_WIDTH-1:0] nxt,
    output logic [CNT_W:0]        word_len,
    output logic                  close,
    output logic                  ws_prev
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_WIDTH + 1);

    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  ws_prev_q, ws_prev_d;
    logic                  ws_chg;

    assign nxt      = {shreg_q[DATA_WIDTH-2:0], sd};
    assign ws_chg   = (ws != ws_prev_q);
    assign close    = sample & ws_chg;
    assign word_len = (CNT_W+1)'(bit_cnt_q) + (CNT_W+1)'(1);
    assign ws_prev  = ws_prev_q;

    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        ws_prev_d = ws_prev_q;
        if (sample) begin
            shreg_d   = nxt;
            ws_prev_d = ws;
            if (ws_chg) begin
                bit_cnt_d = '0;
            end else if (bit_cnt_q != CNT_MAX) begin
                // Saturate so an over-long word can never wrap back to a legal length.
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            ws_prev_q <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            ws_prev_q <= ws_prev_d;
        end
    end

endmodule

// File: rtl/i2s_deserializer.sv
// I2S receiver: aligns words to ws edges and presents complete left/right
// pairs with a one-cycle valid strobe; wrong-length words raise frame_err.
module i2s_deserializer
    import i2s_deserializer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sck,
    input  logic                  sck_transition,
    input  logic                  sd,
    input  logic                  ws,
    output logic [DATA_WIDTH-1:0] left_data,
    output logic [DATA_WIDTH-1:0] right_data,
    output logic                  data_valid,
    output logic                  frame_err,
    output logic                  locked
);

    localparam int CNT_W = cnt_width(DATA_WIDTH);

    logic                  sample;
    logic [DATA_WIDTH-1:0] nxt;
    logic [CNT_W:0]        word_len;
    logic                  close;
    logic                  ws_prev;

    state_e                state_q, state_d;
    logic                  have_left_q, have_left_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] left_q, left_d;
    logic [DATA_WIDTH-1:0] right_q, right_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;

    assign sample = sck_transition & sck;

    i2s_word_assembler #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (CNT_W)
    ) u_asm (
        .clk      (clk),
        .rst_n    (rst_n),
        .sample   (sample),
        .sd       (sd),
        .ws       (ws),
        .nxt      (nxt),
        .word_len (word_len),
        .close    (close),
        .ws_prev  (ws_prev)
    );

    always_comb begin
        state_d     = state_q;
        have_left_d = have_left_q;
        hold_d      = hold_q;
        left_d      = left_q;
        right_d     = right_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sample) state_d = ACQUIRE;
            end
            ACQUIRE: begin
                // The first ws edge only establishes alignment; the partial word is dropped.
                if (close) begin
                    state_d     = RUN;
                    have_left_d = 1'b0;
                end
            end
            RUN: begin
                if (close) begin
                    if (word_len != (CNT_W+1)'(DATA_WIDTH)) begin
                        err_d       = 1'b1;
                        have_left_d = 1'b0;
                    end else if (!ws_prev) begin
                        hold_d      = nxt;
                        have_left_d = 1'b1;
                    end else if (have_left_q) begin
                        left_d      = hold_q;
                        right_d     = nxt;
                        valid_d     = 1'b1;
                        have_left_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            have_left_q <= 1'b0;
            hold_q      <= '0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            have_left_q <= have_left_d;
            hold_q      <= hold_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign left_data  = left_q;
    assign right_data = right_q;
    assign data_valid = valid_q;
    assign frame_err  = err_q;
    assign locked     = (state_q == RUN);

endmodule

// File: tb/tb_i2s_deserializer.sv
// Scoreboard bench for i2s_deserializer: word-level reference model feeds an
// expectation queue, a negedge monitor pops it on every valid/error strobe.
module tb_i2s_deserializer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sck = 1'b0;
    logic         sck_transition = 1'b0;
    logic         sd = 1'b0;
    logic         ws = 1'b0;
    logic [W-1:0] left_data;
    logic [W-1:0] right_data;
    logic         data_valid;
    logic         frame_err;
    logic         locked;

    always #5 clk = ~clk;

    i2s_deserializer #(.DATA_WIDTH(W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sck            (sck),
        .sck_transition (sck_transition),
        .sd             (sd),
        .ws             (ws),
        .left_data      (left_data),
        .right_data     (right_data),
        .data_valid     (data_valid),
        .frame_err      (frame_err),
        .locked         (locked)
    );

    typedef struct {
        bit          ch;
        int          len;
        logic [63:0] val;
    } word_t;

    typedef struct {
        bit           err;
        logic [W-1:0] l;
        logic [W-1:0] r;
    } exp_t;

    word_t words[$];
    exp_t  expq[$];
    int    checks = 0;
    int    errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic void add(input bit ch, input int len, input logic [63:0] val);
        word_t w;
        w.ch  = ch;
        w.len = len;
        w.val = val;
        words.push_back(w);
    endfunction

    // Word-level expectations: word 0 only acquires alignment; afterwards a
    // left word is held, a following right word completes a pair, any
    // wrong-length word is an error that drops a held left word.
    task automatic model(input int driven);
        int           pos;
        bit           hl;
        logic [W-1:0] hold;
        exp_t         e;
        pos  = 0;
        hl   = 1'b0;
        hold = '0;
        for (int k = 0; k < words.size(); k++) begin
            pos += words[k].len;
            if (pos > driven) break;
            if (k == 0) continue;
            if (words[k].len != W) begin
                e.err = 1'b1; e.l = '0; e.r = '0;
                expq.push_back(e);
                hl = 1'b0;
            end else if (!words[k].ch) begin
                hold = words[k].val[W-1:0];
                hl   = 1'b1;
            end else if (hl) begin
                e.err = 1'b0; e.l = hold; e.r = words[k].val[W-1:0];
                expq.push_back(e);
                hl = 1'b0;
            end
        end
    endtask

    task automatic drive_bit(input bit b, input bit w, input int h, input bit fall_p, input bit stray);
        sd = b;
        ws = w;
        sck = 1'b0;
        sck_transition = fall_p;
        tick();
        for (int i = 1; i < h; i++) begin
            sck_transition = (stray && i == h / 2);
            tick();
        end
        sck = 1'b1;
        sck_transition = 1'b1;
        tick();
        sck_transition = 1'b0;
        repeat (h - 1) tick();
    endtask

    // ws switches to the next channel on the LSB of each word (one-bit lead).
    task automatic run(input int h, input bit fall_p, input bit stray, input int stop);
        bit sdb[$];
        bit wsb[$];
        int driven;
        for (int k = 0; k < words.size(); k++) begin
            for (int i = words[k].len - 1; i >= 0; i--) begin
                sdb.push_back(words[k].val[i]);
                if (i == 0) wsb.push_back((k + 1 < words.size()) ? words[k+1].ch : !words[k].ch);
                else        wsb.push_back(words[k].ch);
            end
        end
        driven = (stop < 0 || stop > sdb.size()) ? sdb.size() : stop;
        model(driven);
        for (int n = 0; n < driven; n++) drive_bit(sdb[n], wsb[n], h, fall_p, stray);
        repeat (6) tick();
    endtask

    task automatic finish_scn(input string tag, input bit exp_locked);
        check({tag, "_pending"}, 64'(expq.size()), 64'd0);
        check({tag, "_locked"}, 64'(locked), 64'(exp_locked));
        expq.delete();
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        tick();
        check({tag, "_rst_left"}, 64'(left_data), 64'd0);
        check({tag, "_rst_right"}, 64'(right_data), 64'd0);
        check({tag, "_rst_valid"}, 64'(data_valid), 64'd0);
        check({tag, "_rst_err"}, 64'(frame_err), 64'd0);
        check({tag, "_rst_locked"}, 64'(locked), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        words.delete();
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (data_valid || frame_err) begin
            if (data_valid && frame_err) begin
                checks++;
                errors++;
                $display("FAIL strobe_overlap: valid=1 err=1 expected only one");
            end else if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: valid=%0b err=%0b expected none", data_valid, frame_err);
            end else begin
                e = expq.pop_front();
                check("strobe_kind", 64'(frame_err), 64'(e.err));
                if (!e.err) begin
                    check("left_data", 64'(left_data), 64'(e.l));
                    check("right_data", 64'(right_data), 64'(e.r));
                end
            end
        end
    end

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ch;
        int len;
        int sel;

        // Basic pairs from reset
        do_reset("s1");
        add(1, 3, 64'h0);
        add(0, 16, 64'hAAAA); add(1, 16, 64'hFFFF);
        add(0, 16, 64'h1478); add(1, 16, 64'hA3B9);
        run(40, 0, 0, -1);
        finish_scn("s1", 1);

        // Start mid-right word, first edge 1->0
        do_reset("s2a");
        add(1, 9, 64'h1A5);
        add(0, 16, 64'hCDD7); add(1, 16, 64'hBABA);
        run(40, 0, 0, -1);
        finish_scn("s2a", 1);

        // Acquire on 0->1 so an orphan right word follows
        do_reset("s2b");
        add(0, 5, 64'h15);
        add(1, 16, 64'h5555);
        add(0, 16, 64'hCDD7); add(1, 16, 64'hBABA);
        run(40, 0, 0, -1);
        finish_scn("s2b", 1);

        // Short left word
        do_reset("s3");
        add(1, 3, 64'h5);
        add(0, 15, 64'h1234); add(1, 16, 64'h9999);
        add(0, 16, 64'h4444); add(1, 16, 64'hAAAA);
        run(40, 0, 0, -1);
        finish_scn("s3", 1);

        // Long right words: 20 bits, then 48 bits (would alias to 16 without saturation)
        do_reset("s4");
        add(1, 3, 64'h2);
        add(0, 16, 64'h1111); add(1, 20, 64'hABCDE);
        add(0, 16, 64'h3333); add(1, 48, 64'h1234_5678_9ABC);
        add(0, 16, 64'h0F0F); add(1, 16, 64'hF0F0);
        run(40, 0, 0, -1);
        finish_scn("s4", 1);

        // Reset in the middle of a left word
        do_reset("s5a");
        add(1, 5, 64'h15);
        add(0, 16, 64'h7398); add(1, 16, 64'hFFDD);
        run(40, 0, 0, 5 + 8);
        finish_scn("s5a", 1);
        do_reset("s5b");
        add(1, 4, 64'h9);
        add(0, 16, 64'h1111); add(1, 16, 64'h5982);
        run(40, 0, 0, -1);
        finish_scn("s5b", 1);

        // Falling-edge and stray transition pulses must be ignored
        do_reset("s6");
        add(1, 3, 64'h7);
        add(0, 16, 64'h0001); add(1, 16, 64'hFFFF);
        run(40, 1, 1, -1);
        finish_scn("s6", 1);

        // Randomized streams with occasional wrong-length words
        for (int r = 0; r < 3; r++) begin
            do_reset("rnd");
            ch = 1'($urandom_range(0, 1));
            add(ch, $urandom_range(2, W), {$urandom, $urandom});
            for (int k = 0; k < 10; k++) begin
                ch  = !ch;
                sel = $urandom_range(0, 9);
                len = (sel == 0) ? W - 1 : (sel == 1) ? W + 2 : W;
                add(ch, len, {$urandom, $urandom});
            end
            run(8, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
            finish_scn("rnd", 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
